// File: rtl/mm_feeder.sv
// Input-staging front end for a ROWS x COLS systolic MAC array: per-lane FIFOs, tile FSM and diagonal skew.
// Define MM_FEEDER_PERF_EN to add stall_cnt, a saturating count of cycles spent waiting in FILL.
module mm_feeder #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACT_WIDTH = 16,
  parameter int W_WIDTH   = 4,
  parameter int DEPTH     = 32,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROWS*ACT_WIDTH-1:0] act_din,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [COLS*W_WIDTH-1:0]   w_din,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic                      start,
  input  logic [CW-1:0]             k_len,
  input  logic                      flush,
  output logic [ROWS*ACT_WIDTH-1:0] act_out,
  output logic [ROWS-1:0]           act_vld,
  output logic [COLS*W_WIDTH-1:0]   w_out,
  output logic [COLS-1:0]           w_vld,
  output logic                      busy,
  output logic                      done,
  output logic                      err
`ifdef MM_FEEDER_PERF_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
  localparam int DW   = $clog2(MAXD + 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] k_len_reg, k_len_next;
  logic [CW-1:0] step_reg, step_next;
  logic [DW-1:0] drain_reg, drain_next;
  logic          err_reg, err_next;

  logic [AW-1:0] a_wr_ptr_reg, a_rd_ptr_reg, w_wr_ptr_reg, w_rd_ptr_reg;
  logic [CW-1:0] a_cnt_reg, w_cnt_reg;
  logic [AW-1:0] a_waddr, w_waddr;
  logic          a_push, w_push, pop, clear, k_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Ready looks only at the registered count, so a full FIFO refuses a push even while popping.
  assign act_ready = (a_cnt_reg != CW'(DEPTH));
  assign w_ready   = (w_cnt_reg != CW'(DEPTH));
  assign a_push    = act_valid && act_ready;
  assign w_push    = w_valid && w_ready;
  assign pop       = (state_reg == S_RUN);
  assign clear     = (state_reg == S_IDLE) && flush;
  assign a_waddr   = clear ? '0 : a_wr_ptr_reg;
  assign w_waddr   = clear ? '0 : w_wr_ptr_reg;
  assign k_ok      = (k_len != '0) && (k_len <= CW'(DEPTH));

  // A push arriving alongside a flush lands as the first entry of the emptied FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_wr_ptr_reg <= '0;
      a_rd_ptr_reg <= '0;
      a_cnt_reg    <= '0;
    end else if (clear) begin
      a_wr_ptr_reg <= a_push ? ptr_inc('0) : '0;
      a_rd_ptr_reg <= '0;
      a_cnt_reg    <= a_push ? CW'(1) : '0;
    end else begin
      if (a_push) a_wr_ptr_reg <= ptr_inc(a_wr_ptr_reg);
      if (pop)    a_rd_ptr_reg <= ptr_inc(a_rd_ptr_reg);
      if (a_push && !pop)      a_cnt_reg <= a_cnt_reg + CW'(1);
      else if (!a_push && pop) a_cnt_reg <= a_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_wr_ptr_reg <= '0;
      w_rd_ptr_reg <= '0;
      w_cnt_reg    <= '0;
    end else if (clear) begin
      w_wr_ptr_reg <= w_push ? ptr_inc('0) : '0;
      w_rd_ptr_reg <= '0;
      w_cnt_reg    <= w_push ? CW'(1) : '0;
    end else begin
      if (w_push) w_wr_ptr_reg <= ptr_inc(w_wr_ptr_reg);
      if (pop)    w_rd_ptr_reg <= ptr_inc(w_rd_ptr_reg);
      if (w_push && !pop)      w_cnt_reg <= w_cnt_reg + CW'(1);
      else if (!w_push && pop) w_cnt_reg <= w_cnt_reg - CW'(1);
    end
  end

  // Row gi keeps gi+1 stages; stage 0 doubles as the registered FIFO read.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [ACT_WIDTH-1:0] mem [DEPTH];
      logic [ACT_WIDTH-1:0] stage_reg [gi+1];
      logic                 stage_vld_reg [gi+1];

      always_ff @(posedge clk) begin
        if (a_push) mem[a_waddr] <= act_din[gi*ACT_WIDTH +: ACT_WIDTH];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s <= gi; s++) begin
            stage_reg[s]     <= '0;
            stage_vld_reg[s] <= 1'b0;
          end
        end else begin
          stage_reg[0]     <= pop ? mem[a_rd_ptr_reg] : '0;
          stage_vld_reg[0] <= pop;
          for (int s = 1; s <= gi; s++) begin
            stage_reg[s]     <= stage_reg[s-1];
            stage_vld_reg[s] <= stage_vld_reg[s-1];
          end
        end
      end

      assign act_out[gi*ACT_WIDTH +: ACT_WIDTH] = stage_reg[gi];
      assign act_vld[gi]                        = stage_vld_reg[gi];
    end

    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [W_WIDTH-1:0] mem [DEPTH];
      logic [W_WIDTH-1:0] stage_reg [gi+1];
      logic               stage_vld_reg [gi+1];

      always_ff @(posedge clk) begin
        if (w_push) mem[w_waddr] <= w_din[gi*W_WIDTH +: W_WIDTH];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s <= gi; s++) begin
            stage_reg[s]     <= '0;
            stage_vld_reg[s] <= 1'b0;
          end
        end else begin
          stage_reg[0]     <= pop ? mem[w_rd_ptr_reg] : '0;
          stage_vld_reg[0] <= pop;
          for (int s = 1; s <= gi; s++) begin
            stage_reg[s]     <= stage_reg[s-1];
            stage_vld_reg[s] <= stage_vld_reg[s-1];
          end
        end
      end

      assign w_out[gi*W_WIDTH +: W_WIDTH] = stage_reg[gi];
      assign w_vld[gi]                    = stage_vld_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      k_len_reg <= '0;
      step_reg  <= '0;
      drain_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_len_reg <= k_len_next;
      step_reg  <= step_next;
      drain_reg <= drain_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_len_next = k_len_reg;
    step_next  = step_reg;
    drain_next = drain_reg;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!flush && start) begin
          if (k_ok) begin
            state_next = S_FILL;
            k_len_next = k_len;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (a_cnt_reg >= k_len_reg && w_cnt_reg >= k_len_reg) begin
          state_next = S_RUN;
          step_next  = '0;
        end
      end
      S_RUN: begin
        if (step_reg == k_len_reg - CW'(1)) begin
          state_next = S_DRAIN;
          step_next  = '0;
          drain_next = '0;
        end else begin
          step_next = step_reg + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_reg == DW'(MAXD - 1)) state_next = S_DONE;
        else                            drain_next = drain_reg + DW'(1);
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);
  assign err  = err_reg;

`ifdef MM_FEEDER_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic        start_ok;
  assign start_ok = (state_reg == S_IDLE) && !flush && start && k_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                             stall_cnt_reg <= '0;
    else if (start_ok)                                    stall_cnt_reg <= '0;
    else if (state_reg == S_FILL && stall_cnt_reg != '1)  stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: doc/mm_feeder.md
Name: mm_feeder

Overview:
- Parametrised input-staging front end for a ROWS x COLS systolic MAC array. Successor to the square mm top with 1-bit weights.
- Buffers activations per row and multi-bit weights per column in FIFOs with valid/ready ingress.
- Runs a k_len-step tile under an FSM and emits diagonally skewed lanes: row i delayed i cycles, column j delayed j cycles.
- Pulses done once the skew has drained.

Parameters:
- ROWS, 4, activation lanes (array rows), >=1
- COLS, 4, weight lanes (array columns), >=1
- ACT_WIDTH, 16, activation lane width
- W_WIDTH, 4, weight lane width (1..8; INT weight)
- DEPTH, 32, entries per FIFO, power of 2; max k_len
- CW, $clog2(DEPTH+1), count/k_len width (derived, do not override)

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-low reset
- act_din, in, ROWS*ACT_WIDTH, one activation word per row (row i at [i*ACT_WIDTH +: ACT_WIDTH])
- act_valid, in, 1, act_din push request
- act_ready, out, 1, every act FIFO not full
- w_din, in, COLS*W_WIDTH, one weight word per column
- w_valid, in, 1, w_din push request
- w_ready, out, 1, every w FIFO not full
- start, in, 1, begin tile (sampled in IDLE only)
- k_len, in, CW, tile length, sampled with start
- flush, in, 1, clear all FIFOs (honoured in IDLE only)
- act_out, out, ROWS*ACT_WIDTH, skewed activation lanes
- act_vld, out, ROWS, per-row lane valid
- w_out, out, COLS*W_WIDTH, skewed weight lanes
- w_vld, out, COLS, per-column lane valid
- busy, out, 1, state != IDLE
- done, out, 1, one-cycle tile-complete pulse
- err, out, 1, one-cycle pulse on rejected start

Behaviour:
- Reset (rst=0, async):
  - FIFOs empty, state IDLE, skew registers zero.
  - Outputs: act_out/w_out/act_vld/w_vld = 0, busy=0, done=0, err=0, act_ready=w_ready=1.
  - Reset mid-tile aborts the tile; no done.
- Push:
  - A push occurs when valid&&ready, written to all lanes of that side at once.
  - Pushes are accepted in any state.
  - ready is computed from the registered count only: a full FIFO does not accept a push even if it pops the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, FILL, RUN, DRAIN, DONE.
  - IDLE: start with 1<=k_len<=DEPTH latches k_len and goes to FILL. start with k_len==0 or k_len>DEPTH pulses err next cycle and stays in IDLE. flush with start in the same cycle: flush wins, start ignored.
  - FILL: waits until act count>=k_len and w count>=k_len, evaluated on registered counts, then goes to RUN.
  - RUN: exactly k_len cycles. Each cycle pops one entry from every FIFO; a step counter runs 0..k_len-1; then goes to DRAIN.
  - DRAIN: exactly max(ROWS,COLS) cycles, no pops, skew stage 0 loads zeros with valid=0; then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE. A start during DONE is ignored.
- Skew and latency:
  - A popped word is registered into lane stage 0 at the end of the pop cycle.
  - Row i output is stage i, so row i's word from RUN cycle t appears at RUN-relative cycle t+1+i with act_vld[i]=1. Columns are identical with j.
  - Valid bits travel with the data; lanes show zero data when not valid.
  - The last valid output is at cycle k_len+max(ROWS,COLS)-1; done is asserted at cycle k_len+max(ROWS,COLS).
- Ordering: each FIFO is strictly FIFO. Pointers wrap modulo DEPTH.
- Data written during FILL/RUN queues behind the current tile and is consumed by the next tile.

Optional Feature:
- Macro MM_FEEDER_PERF_EN.
- Defined:
  - Adds output stall_cnt (32 bits), counting cycles spent in FILL.
  - Cleared by reset and on each accepted start; saturates at 2^32-1.
- Undefined: no port, no counter logic.

Test Plan:
- ROWS=COLS=4, DEPTH=32. Push 8 act and 8 w vectors, start k_len=8 -> RUN 8 cycles; act_vld[3] high at RUN cycles 4..11; done at cycle 12; FIFOs empty after.
- Start k_len=4 with FIFOs empty, push 4 vectors 10 cycles later -> stays in FILL until both counts reach 4. With MM_FEEDER_PERF_EN, stall_cnt = cycles in FILL (>=10).
- Start k_len=0, then start k_len=33 -> err pulse each, busy stays 0.
- Fill to 32 -> act_ready=0, extra push dropped. Run k_len=32 while pushing -> pushes resume once count<32; next tile outputs the new data in order.
- Assert rst=0 mid-RUN -> all outputs 0 at once, no done, FIFOs empty. flush in IDLE after 5 pushes -> counts 0.
- ROWS=2, COLS=5, k_len=3 -> DRAIN 5 cycles; w_vld[4] at cycles 5..7; done at cycle 8.
